// File: rtl/stack_push_pop_unit_if.sv
// Memory-side handshake bundle for stack_push_pop_unit: request/write-data out,
// acknowledge/read-data back.
interface stack_push_pop_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                    input  mem_ack, mem_rdata);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                    output mem_ack, mem_rdata);
endinterface

// File: rtl/stack_push_pop_unit.sv
// PUSH/POP sequencer: one handshaked memory access, then a single-cycle pointer
// commit to the stack address register. Optional bound check: STACK_BOUND_CHECK_EN.
module stack_push_pop_unit #(
    parameter logic [31:0] STACK_LIMIT_LO = 32'h0000_0100,
    parameter logic [31:0] STACK_LIMIT_HI = 32'h0000_0999
) (
    input  logic                          clock_4,
    input  logic                          reset,
    input  logic                          op_valid,
    input  logic                          op_pop,
    input  logic [31:0]                   push_data,
    input  logic [31:0]                   stack_addr,
    stack_push_pop_unit_if.master         mem,
    output logic [3:0]                    read_or_write,
    output logic [31:0]                   write_data,
    output logic                          busy,
    output logic                          op_done,
    output logic [31:0]                   pop_data,
    output logic                          stack_err
);

`ifdef STACK_BOUND_CHECK_EN
    typedef enum logic [2:0] {IDLE, MEM, COMMIT, DONE, ERR} state_t;
`else
    typedef enum logic [1:0] {IDLE, MEM, COMMIT, DONE} state_t;
`endif

    state_t      state_q, state_d;
    logic        pop_q, pop_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] new_ptr_q, new_ptr_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] pop_data_q, pop_data_d;

    logic [31:0] ptr_minus, ptr_plus;
    assign ptr_minus = stack_addr - 32'd4;
    assign ptr_plus  = stack_addr + 32'd4;

`ifdef STACK_BOUND_CHECK_EN
    // 33-bit compares so a pointer that would wrap is treated as out of bounds.
    logic bound_viol;
    always_comb begin
        if (op_pop)
            bound_viol = ({1'b0, stack_addr} + 33'd4) > {1'b0, STACK_LIMIT_HI};
        else
            bound_viol = {1'b0, stack_addr} < ({1'b0, STACK_LIMIT_LO} + 33'd4);
    end
`else
    logic unused_limits;
    assign unused_limits = ^{STACK_LIMIT_LO, STACK_LIMIT_HI};
`endif

    always_comb begin
        state_d    = state_q;
        pop_d      = pop_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        new_ptr_d  = new_ptr_q;
        rdata_d    = rdata_q;
        pop_data_d = pop_data_q;
        case (state_q)
            IDLE: begin
                if (op_valid) begin
                    pop_d     = op_pop;
                    wdata_d   = push_data;
                    addr_d    = op_pop ? stack_addr : ptr_minus;
                    new_ptr_d = op_pop ? ptr_plus : ptr_minus;
                    state_d   = MEM;
`ifdef STACK_BOUND_CHECK_EN
                    if (bound_viol) state_d = ERR;
`endif
                end
            end
            MEM: begin
                if (mem.mem_ack) begin
                    if (pop_q) rdata_d = mem.mem_rdata;
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                if (pop_q) pop_data_d = rdata_q;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_4) begin
        if (!reset) begin
            state_q    <= IDLE;
            pop_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            new_ptr_q  <= '0;
            rdata_q    <= '0;
            pop_data_q <= '0;
        end else begin
            state_q    <= state_d;
            pop_q      <= pop_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            new_ptr_q  <= new_ptr_d;
            rdata_q    <= rdata_d;
            pop_data_q <= pop_data_d;
        end
    end

    assign mem.mem_req   = (state_q == MEM);
    assign mem.mem_we    = (state_q == MEM) && !pop_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    // Gated by reset so an operation aborted during COMMIT never writes the pointer.
    assign read_or_write = (state_q == COMMIT && reset) ? 4'h5 : 4'h0;
    assign write_data    = new_ptr_q;
    assign busy          = (state_q != IDLE);
    assign pop_data      = pop_data_q;

`ifdef STACK_BOUND_CHECK_EN
    assign op_done   = (state_q == DONE) || (state_q == ERR);
    assign stack_err = (state_q == ERR);
`else
    assign op_done   = (state_q == DONE);
    assign stack_err = 1'b0;
`endif

endmodule

// File: tb/tb_stack_push_pop_unit.sv
// Directed bench for stack_push_pop_unit with a behavioural stack address register.
module tb_stack_push_pop_unit;
    logic        clk;
    logic        rst_n;
    logic        op_valid, op_pop;
    logic [31:0] push_data;
    logic [31:0] sa_q;
    logic [3:0]  rw;
    logic [31:0] wd, pop_data;
    logic        busy, op_done, stack_err;
    logic        sa_set;
    logic [31:0] sa_val;
    int          commits;
    int          errors, checks;

    stack_push_pop_unit_if mif();

    stack_push_pop_unit dut (
        .clock_4(clk), .reset(rst_n), .op_valid(op_valid), .op_pop(op_pop),
        .push_data(push_data), .stack_addr(sa_q), .mem(mif),
        .read_or_write(rw), .write_data(wd), .busy(busy), .op_done(op_done),
        .pop_data(pop_data), .stack_err(stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stack address register: takes write_data on a 4'h5 command.
    always @(posedge clk) begin
        if (sa_set) sa_q <= sa_val;
        else if (rw == 4'h5) begin
            sa_q    <= wd;
            commits <= commits + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preset(input logic [31:0] v);
        sa_set = 1'b1; sa_val = v;
        tick();
        sa_set = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; op_valid = 1'b1; op_pop = 1'b0; push_data = 32'hFFFF_FFFF;
        tick(); tick();
        checks++;
        if ({mif.mem_req, mif.mem_we, busy, op_done, stack_err} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got=%b exp=00000", {mif.mem_req, mif.mem_we, busy, op_done, stack_err});
        end
        checks++;
        if ({rw, wd, mif.mem_addr, mif.mem_wdata, pop_data} !== '0) begin
            errors++; $display("FAIL reset_data rw=%h wd=%h addr=%h wdata=%h pop=%h exp=0", rw, wd, mif.mem_addr, mif.mem_wdata, pop_data);
        end
        op_valid = 1'b0; rst_n = 1'b1;
        tick();
    endtask

    task automatic test_push();
        preset(32'h999);
        op_valid = 1'b1; op_pop = 1'b0; push_data = 32'hDEAD_BEEF;
        tick();                                  // cycle 1: MEM
        op_valid = 1'b0; mif.mem_ack = 1'b1;
        checks++;
        if ({mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata} !== {2'b11, 32'h995, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL push_mem got req=%b we=%b addr=%h wdata=%h exp 1 1 995 deadbeef", mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_wdata);
        end
        tick();                                  // cycle 2: COMMIT
        mif.mem_ack = 1'b0;
        checks++;
        if ({rw, wd, mif.mem_req} !== {4'h5, 32'h995, 1'b0}) begin
            errors++; $display("FAIL push_commit got rw=%h wd=%h req=%b exp 5 995 0", rw, wd, mif.mem_req);
        end
        tick();                                  // cycle 3: DONE
        checks++;
        if ({op_done, busy, stack_err, rw, sa_q} !== {3'b110, 4'h0, 32'h995}) begin
            errors++; $display("FAIL push_done got done=%b busy=%b err=%b rw=%h sa=%h exp 1 1 0 0 995", op_done, busy, stack_err, rw, sa_q);
        end
        tick();
        checks++;
        if ({op_done, busy, pop_data} !== {2'b00, 32'h0}) begin
            errors++; $display("FAIL push_idle got done=%b busy=%b pop=%h exp 0 0 0", op_done, busy, pop_data);
        end
    endtask

    task automatic test_pop_wait();
        int req_cycles = 0;
        op_valid = 1'b1; op_pop = 1'b1; mif.mem_rdata = 32'h1234_5678;
        tick();                                  // cycle 1
        op_valid = 1'b0;
        checks++;
        if ({mif.mem_we, mif.mem_addr} !== {1'b0, 32'h995}) begin
            errors++; $display("FAIL pop_mem got we=%b addr=%h exp 0 995", mif.mem_we, mif.mem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            if (mif.mem_req) req_cycles++;
            tick();
        end
        mif.mem_ack = 1'b1;                      // cycle 4
        if (mif.mem_req) req_cycles++;
        tick();                                  // cycle 5: COMMIT
        mif.mem_ack = 1'b0; mif.mem_rdata = 32'h0;
        checks++;
        if (req_cycles !== 4 || mif.mem_req !== 1'b0) begin
            errors++; $display("FAIL pop_req_len got=%0d req=%b exp 4 0", req_cycles, mif.mem_req);
        end
        checks++;
        if ({rw, wd, pop_data} !== {4'h5, 32'h999, 32'h0}) begin
            errors++; $display("FAIL pop_commit got rw=%h wd=%h pop=%h exp 5 999 0", rw, wd, pop_data);
        end
        tick();                                  // cycle 6: DONE
        checks++;
        if ({op_done, pop_data, sa_q} !== {1'b1, 32'h1234_5678, 32'h999}) begin
            errors++; $display("FAIL pop_done got done=%b pop=%h sa=%h exp 1 12345678 999", op_done, pop_data, sa_q);
        end
        tick(); tick();
        checks++;
        if ({busy, pop_data} !== {1'b0, 32'h1234_5678}) begin
            errors++; $display("FAIL pop_hold got busy=%b pop=%h exp 0 12345678", busy, pop_data);
        end
    endtask

    task automatic test_abort();
        int c0 = commits;
        op_valid = 1'b1; op_pop = 1'b0; push_data = 32'h55AA_55AA;
        tick();                                  // MEM
        op_valid = 1'b1; op_pop = 1'b1; mif.mem_ack = 1'b1;
        tick();                                  // COMMIT
        op_valid = 1'b0; mif.mem_ack = 1'b0;
        checks++;
        if ({busy, mif.mem_addr} !== {1'b1, 32'h995}) begin
            errors++; $display("FAIL abort_commit_state got busy=%b addr=%h exp 1 995", busy, mif.mem_addr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rw !== 4'h0) begin
            errors++; $display("FAIL abort_rw got=%h exp=0", rw);
        end
        tick();
        checks++;
        if ({busy, mif.mem_req, op_done, mif.mem_addr, wd, sa_q} !== {3'b000, 32'h0, 32'h0, 32'h999}) begin
            errors++; $display("FAIL abort_idle got busy=%b req=%b done=%b addr=%h wd=%h sa=%h exp 0 0 0 0 0 999", busy, mif.mem_req, op_done, mif.mem_addr, wd, sa_q);
        end
        rst_n = 1'b1;
        tick(); tick();
        checks++;
        if (busy !== 1'b0 || commits !== c0) begin
            errors++; $display("FAIL abort_no_queue got busy=%b commits=%0d exp 0 %0d", busy, commits, c0);
        end
    endtask

`ifdef STACK_BOUND_CHECK_EN
    task automatic test_bound();
        int c0;
        preset(32'h102);
        c0 = commits;
        op_valid = 1'b1; op_pop = 1'b0; push_data = 32'h1;
        tick();                                  // cycle 1: ERR
        op_valid = 1'b0;
        checks++;
        if ({stack_err, op_done, busy, mif.mem_req} !== 4'b1110) begin
            errors++; $display("FAIL bound_push got err=%b done=%b busy=%b req=%b exp 1 1 1 0", stack_err, op_done, busy, mif.mem_req);
        end
        tick();
        checks++;
        if ({stack_err, op_done, busy} !== 3'b000 || commits !== c0 || sa_q !== 32'h102) begin
            errors++; $display("FAIL bound_after got err=%b done=%b busy=%b commits=%0d sa=%h exp 0 0 0 %0d 102", stack_err, op_done, busy, commits, sa_q, c0);
        end
        preset(32'h998);
        op_valid = 1'b1; op_pop = 1'b1;
        tick();
        op_valid = 1'b0;
        checks++;
        if ({stack_err, mif.mem_req, pop_data} !== {2'b10, 32'h1234_5678}) begin
            errors++; $display("FAIL bound_pop got err=%b req=%b pop=%h exp 1 0 12345678", stack_err, mif.mem_req, pop_data);
        end
        tick();
    endtask
`else
    task automatic test_wrap();
        preset(32'h0);
        op_valid = 1'b1; op_pop = 1'b0; push_data = 32'hCAFE_0001;
        tick();
        op_valid = 1'b0; mif.mem_ack = 1'b1;
        checks++;
        if ({mif.mem_req, mif.mem_addr, stack_err} !== {1'b1, 32'hFFFF_FFFC, 1'b0}) begin
            errors++; $display("FAIL wrap_mem got req=%b addr=%h err=%b exp 1 fffffffc 0", mif.mem_req, mif.mem_addr, stack_err);
        end
        tick();
        mif.mem_ack = 1'b0;
        checks++;
        if ({rw, wd} !== {4'h5, 32'hFFFF_FFFC}) begin
            errors++; $display("FAIL wrap_commit got rw=%h wd=%h exp 5 fffffffc", rw, wd);
        end
        tick();
        checks++;
        if ({op_done, stack_err, sa_q} !== {2'b10, 32'hFFFF_FFFC}) begin
            errors++; $display("FAIL wrap_done got done=%b err=%b sa=%h exp 1 0 fffffffc", op_done, stack_err, sa_q);
        end
        tick();
    endtask
`endif

    initial begin
        errors = 0; checks = 0; commits = 0;
        rst_n = 1'b0; op_valid = 1'b0; op_pop = 1'b0; push_data = '0;
        mif.mem_ack = 1'b0; mif.mem_rdata = '0;
        sa_set = 1'b1; sa_val = 32'h999;
        tick();
        sa_set = 1'b0;
        test_reset();
        test_push();
        test_pop_wait();
        test_abort();
`ifdef STACK_BOUND_CHECK_EN
        test_bound();
`else
        test_wrap();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stack_push_pop_unit.md
# stack_push_pop_unit

Sequencer that executes PUSH and POP operations against data memory and updates the stack pointer. It reads the current pointer from the stack address register, performs one handshaked memory access, then commits the new pointer by driving the register's write port (`read_or_write` = 4'h5, `write_data` = new pointer). It sits directly upstream of the stack address register, between instruction decode and the memory interface.

## Interface
Parameters:
- STACK_LIMIT_LO, 32'h0000_0100, lowest legal push address (bound check only)
- STACK_LIMIT_HI, 32'h0000_0999, highest legal pointer after pop (bound check only)

Ports:
- clock_4  input  1  single clock; all logic on rising edge
- reset  input  1  synchronous, active-low reset
- op_valid  input  1  operation request, sampled only in IDLE
- op_pop  input  1  0 = PUSH, 1 = POP; qualified by op_valid
- push_data  input  32  data to push; captured at acceptance
- stack_addr  input  32  current pointer from the stack address register
- mem_req  output  1  memory request, held until acknowledged
- mem_we  output  1  1 = write (PUSH), 0 = read (POP)
- mem_addr  output  32  memory word address
- mem_wdata  output  32  write data
- mem_ack  input  1  memory acknowledge; mem_rdata valid in the same cycle
- mem_rdata  input  32  read data
- read_or_write  output  4  4'h5 for exactly one cycle to commit the pointer, else 4'h0
- write_data  output  32  new pointer value, valid when read_or_write == 4'h5
- busy  output  1  high in every state except IDLE
- op_done  output  1  one-cycle completion pulse
- pop_data  output  32  popped value, held from op_done until the next POP completes
- stack_err  output  1  one-cycle bound-violation pulse

## Operation
- States: IDLE, MEM, COMMIT, DONE, and ERR (ERR exists only when the bound check is compiled in).
- IDLE: when op_valid = 1, capture op_pop, push_data, and stack_addr, then go to MEM. When op_valid = 0, stay in IDLE.
- PUSH address: stack_addr − 4. New pointer: stack_addr − 4.
- POP address: stack_addr. New pointer: stack_addr + 4.
- All pointer arithmetic is 32-bit modulo 2^32. Alignment is not checked.
- MEM:
  - mem_req = 1, with mem_we, mem_addr, and mem_wdata stable.
  - When mem_ack = 1: latch mem_rdata for POP, then go to COMMIT.
  - With no ack, stay in MEM indefinitely. There is no timeout.
- COMMIT: read_or_write = 4'h5 and write_data = new pointer for one cycle, then go to DONE.
- DONE: op_done = 1 for one cycle and pop_data updates (POP only), then go to IDLE.
- op_valid outside IDLE is ignored. Operations are not queued and upstream must retry.
- Reset (reset = 0 at a rising edge), including mid-operation:
  - State goes to IDLE.
  - mem_req, mem_we, busy, op_done, and stack_err go to 0.
  - read_or_write goes to 4'h0; write_data, mem_addr, mem_wdata, and pop_data go to 0.
  - An aborted operation never commits the pointer.

## Timing
- Accept at cycle 0. MEM starts at cycle 1.
- With mem_ack in cycle 1: COMMIT in cycle 2, DONE in cycle 3. Minimum latency is 3 cycles from accept to op_done; each wait cycle on mem_ack adds one.
- The pointer register updates on the edge ending COMMIT, so stack_addr shows the new value in DONE.
- IDLE can accept a new operation in the cycle after DONE. Back-to-back throughput is one operation per 4 cycles minimum.
- mem_req rises in the first MEM cycle and falls in the cycle after the ack.

## Configuration
- STACK_BOUND_CHECK_EN defined:
  - At acceptance, a PUSH with stack_addr − 4 < STACK_LIMIT_LO, or a POP with stack_addr + 4 > STACK_LIMIT_HI, goes to ERR instead of MEM.
  - Comparisons are unsigned 33-bit, so wrap-around counts as a violation.
  - ERR: stack_err = 1 and op_done = 1 for one cycle, then go to IDLE.
  - A violating operation makes no memory access and no pointer commit, and pop_data is unchanged.
- STACK_BOUND_CHECK_EN undefined:
  - No ERR state and stack_err is tied to 0.
  - Pointer wraps modulo 2^32: a PUSH at 32'h0 writes 32'hFFFF_FFFC.

## Test plan
- Reset for 2 cycles with op_valid = 1 → all outputs 0, busy = 0, no mem_req.
- stack_addr = 32'h999, PUSH of 32'hDEAD_BEEF, ack in first MEM cycle → mem_addr = 32'h995 with mem_we = 1. read_or_write = 4'h5 with write_data = 32'h995 in cycle 2. op_done in cycle 3.
- stack_addr = 32'h995, POP, mem_ack held off 3 cycles, mem_rdata = 32'h1234_5678 → mem_req held 4 cycles. write_data = 32'h999. pop_data = 32'h1234_5678 at op_done in cycle 6.
- op_valid pulsed during MEM, then reset asserted in COMMIT → second request ignored. read_or_write never equals 4'h5; state returns to IDLE.
- With STACK_BOUND_CHECK_EN, stack_addr = 32'h102, PUSH → no mem_req. stack_err and op_done pulse in cycle 1; no commit.
- Without STACK_BOUND_CHECK_EN, stack_addr = 32'h0, PUSH → mem_addr = 32'hFFFF_FFFC, write_data = 32'hFFFF_FFFC, stack_err = 0.
